// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding shared by multicycle_alu
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_LSL   = 4'b0011;
   localparam logic [3:0] OP_LSR   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_mul_unit.sv
// rtl/alu_mul_unit.sv - iterative shift-add unsigned multiplier, WIDTH iterations per product
module alu_mul_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   always_comb begin
      busy_d   = busy_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         // done is a one-cycle pulse registered after the final add
         if (cnt_q == LAST_ITER) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign done_o    = done_q;
   assign product_o = acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - ALU with valid/ready handshake; MUL datapath built only with MULTICYCLE_ALU_MUL_EN
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [3:0]       ALUCtrl,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] BusW,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow
);

   localparam int SH_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] busw_q, busw_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   add_wide, sub_wide;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic             alu_is_mul;
   logic             accept;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign accept   = InValid && (state_q == ST_IDLE);
   assign add_wide = {1'b0, BusA} + {1'b0, BusB};
   assign sub_wide = {1'b0, BusA} - {1'b0, BusB};

   always_comb begin
      alu_res    = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      alu_is_mul = 1'b0;
      case (ALUCtrl)
         OP_AND:   alu_res = BusA & BusB;
         OP_OR:    alu_res = BusA | BusB;
         OP_ADD: begin
            alu_res = add_wide[WIDTH-1:0];
            alu_c   = add_wide[WIDTH];
            alu_v   = (BusA[WIDTH-1] == BusB[WIDTH-1]) &&
                      (add_wide[WIDTH-1] != BusA[WIDTH-1]);
         end
         OP_LSL:   alu_res = BusA << BusB[SH_W-1:0];
         OP_LSR:   alu_res = BusA >> BusB[SH_W-1:0];
         OP_SUB: begin
            // carry means "no borrow", i.e. BusA >= BusB unsigned
            alu_res = sub_wide[WIDTH-1:0];
            alu_c   = ~sub_wide[WIDTH];
            alu_v   = (BusA[WIDTH-1] != BusB[WIDTH-1]) &&
                      (sub_wide[WIDTH-1] != BusA[WIDTH-1]);
         end
         OP_PASSB: alu_res = BusB;
`ifdef MULTICYCLE_ALU_MUL_EN
         OP_MUL:   alu_is_mul = 1'b1;
`endif
         default:  alu_res = '0;
      endcase
   end

`ifdef MULTICYCLE_ALU_MUL_EN
   alu_mul_unit #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk       (CLK),
      .rst       (Reset),
      .start_i   (accept && alu_is_mul),
      .a_i       (BusA),
      .b_i       (BusB),
      .done_o    (mul_done),
      .product_o (mul_product)
   );
`else
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   always_comb begin
      state_d = state_q;
      busw_d  = busw_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (alu_is_mul) begin
                  state_d = ST_MUL;
               end else begin
                  state_d = ST_DONE;
                  busw_d  = alu_res;
                  zero_d  = (alu_res == '0);
                  neg_d   = alu_res[WIDTH-1];
                  carry_d = alu_c;
                  ovf_d   = alu_v;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_d = ST_DONE;
               busw_d  = mul_product;
               zero_d  = (mul_product == '0);
               neg_d   = mul_product[WIDTH-1];
               carry_d = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         ST_DONE: begin
            if (OutReady) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         busw_q  <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busw_q  <= busw_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign InReady  = (state_q == ST_IDLE);
   assign OutValid = (state_q == ST_DONE);
   assign BusW     = busw_q;
   assign Zero     = zero_q;
   assign Negative = neg_q;
   assign Carry    = carry_q;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu, WIDTH=64
module tb_multicycle_alu;

   localparam int W = 64;
`ifdef MULTICYCLE_ALU_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          Reset, InValid, InReady, OutValid, OutReady;
   logic [W-1:0]  BusA, BusB, BusW;
   logic [3:0]    ALUCtrl;
   logic          Zero, Negative, Carry, Overflow;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_alu #(.WIDTH(W)) dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .OutValid(OutValid),
      .OutReady(OutReady), .BusW(BusW), .Zero(Zero), .Negative(Negative),
      .Carry(Carry), .Overflow(Overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] w;
      logic z, n, c, v;
   } res_t;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, w;
      logic         z, n, c, v;
   } vec_t;

   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      logic [W:0] wide;
      logic [2*W-1:0] prod;
      logic signed [W+1:0] s;
      r = '0;
      case (op)
         4'd0: r.w = a & b;
         4'd1: r.w = a | b;
         4'd2: begin
            wide = {1'b0, a} + {1'b0, b};
            r.w = wide[W-1:0];
            r.c = wide[W];
            s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
            r.v = (s != $signed({{2{r.w[W-1]}}, r.w}));
         end
         4'd3: r.w = a << b[5:0];
         4'd4: r.w = a >> b[5:0];
         4'd6: begin
            r.w = a - b;
            r.c = (a >= b);
            s = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
            r.v = (s != $signed({{2{r.w[W-1]}}, r.w}));
         end
         4'd7: r.w = b;
         4'd8: begin
            if (MUL_ON) begin
               prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
               r.w = prod[W-1:0];
            end
         end
         default: r.w = '0;
      endcase
      r.z = (r.w == '0);
      r.n = r.w[W-1];
      return r;
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
      return (MUL_ON && op == 4'd8) ? W + 1 : 1;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Offer one op, then wait (bounded) for OutValid; inputs are scrambled after acceptance.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic saw_ready);
      @(negedge CLK);
      BusA = a; BusB = b; ALUCtrl = op; InValid = 1'b1;
      @(negedge CLK);
      BusA = {$urandom, $urandom}; BusB = {$urandom, $urandom};
      ALUCtrl = 4'($urandom); InValid = 1'b0;
      lat = 1;
      saw_ready = 1'b0;
      while (!OutValid && lat < 200) begin
         if (InReady) saw_ready = 1'b1;
         InValid = 1'($urandom);
         @(negedge CLK);
         lat++;
      end
      InValid = 1'b0;
   endtask

   task automatic handoff();
      OutReady = 1'b1;
      InValid  = 1'b0;
      @(negedge CLK);
      OutReady = 1'b0;
      check("handoff_outvalid", 64'(OutValid), 64'd0);
      check("handoff_inready", 64'(InReady), 64'd1);
   endtask

   task automatic run_and_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input res_t e);
      int lat;
      logic saw;
      issue(op, a, b, lat, saw);
      check({tag, "_busw"}, BusW, e.w);
      check({tag, "_flags"}, 64'({Zero, Negative, Carry, Overflow}), 64'({e.z, e.n, e.c, e.v}));
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat(op)));
      check({tag, "_busy_ready"}, 64'(saw), 64'd0);
      handoff();
   endtask

   vec_t tbl[13];

   initial begin
      res_t e;
      logic [3:0] op;
      logic [W-1:0] a, b;
      int lat;
      logic saw, leaked;

      tbl[0]  = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{4'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{4'd1, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{4'd0, 64'hF0, 64'h0F, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{4'd3, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{4'd3, 64'h3, 64'd65, 64'h6, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{4'd4, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{4'd7, 64'h1234, 64'hDEAD, 64'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{4'd6, 64'h5, 64'h5, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{4'd5, 64'h1, 64'h2, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'd15, 64'hFFFF, 64'hFFFF, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef MULTICYCLE_ALU_MUL_EN
      tbl[12] = '{4'd8, 64'd7, 64'd9, 64'd63, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      tbl[12] = '{4'd8, 64'd7, 64'd9, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

      Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
      BusA = '0; BusB = '0; ALUCtrl = '0;
      repeat (2) @(negedge CLK);
      check("reset_outvalid", 64'(OutValid), 64'd0);
      check("reset_busw", BusW, 64'd0);
      check("reset_flags", 64'({Zero, Negative, Carry, Overflow}), 64'd0);
      Reset = 1'b0;
      @(negedge CLK);
      check("post_reset_inready", 64'(InReady), 64'd1);

      for (int i = 0; i < 13; i++) begin
         e.w = tbl[i].w; e.z = tbl[i].z; e.n = tbl[i].n; e.c = tbl[i].c; e.v = tbl[i].v;
         run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e);
      end

      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: a = '0;
            1: a = '1;
            2: a = 64'h8000_0000_0000_0000;
            default: a = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 5))
            0: b = 64'($urandom_range(0, 70));
            1: b = '1;
            2: b = 64'h7FFF_FFFF_FFFF_FFFF;
            default: b = {$urandom, $urandom};
         endcase
         run_and_check($sformatf("rnd%0d_op%0d", i, op), op, a, b, model(op, a, b));
      end

      // Consumer stalls for five cycles while new offers are pulsed in.
      issue(4'd2, 64'd1, 64'd2, lat, saw);
      check("stall_first_latency", 64'(lat), 64'd1);
      for (int i = 0; i < 5; i++) begin
         InValid = 1'(i % 2 == 0);
         BusA = {$urandom, $urandom}; ALUCtrl = 4'($urandom);
         @(negedge CLK);
         check("stall_busw", BusW, 64'd3);
         check("stall_flags", 64'({Zero, Negative, Carry, Overflow}), 64'd0);
         check("stall_outvalid", 64'(OutValid), 64'd1);
         check("stall_inready", 64'(InReady), 64'd0);
      end
      handoff();

      // Reset while a MUL is iterating (or parked in DONE without the multiplier).
      @(negedge CLK);
      BusA = '1; BusB = 64'h1234_5678_9ABC_DEF1; ALUCtrl = 4'd8; InValid = 1'b1;
      @(negedge CLK);
      InValid = 1'b0;
      repeat (9) @(negedge CLK);
      check("mid_mul_inready", 64'(InReady), 64'd0);
      check("mid_mul_outvalid", 64'(OutValid), MUL_ON ? 64'd0 : 64'd1);
      Reset = 1'b1;
      #1;
      check("async_reset_outvalid", 64'(OutValid), 64'd0);
      check("async_reset_inready", 64'(InReady), 64'd1);
      check("async_reset_busw", BusW, 64'd0);
      @(negedge CLK);
      Reset = 1'b0;
      leaked = 1'b0;
      for (int i = 0; i < W + 6; i++) begin
         @(negedge CLK);
         if (OutValid) leaked = 1'b1;
      end
      check("reset_discard", 64'(leaked), 64'd0);
      e = '0; e.w = 64'hFF;
      run_and_check("after_reset_or", 4'd1, 64'hF0, 64'h0F, e);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port InValid, input, 1 bit: an operation is offered.
REQ-005 SHALL have port InReady, output, 1 bit: the block can accept an operation.
REQ-006 SHALL have ports BusA and BusB, inputs, WIDTH bits each: the operands.
REQ-007 SHALL have port ALUCtrl, input, 4 bits: the opcode.
REQ-008 SHALL have port OutValid, output, 1 bit: a result is held on the outputs.
REQ-009 SHALL have port OutReady, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port BusW, output, WIDTH bits: the registered result.
REQ-011 SHALL have ports Zero, Negative, Carry and Overflow, outputs, 1 bit each: the registered flags.

Function
REQ-012 SHALL decode opcodes AND=0000, OR=0001, ADD=0010, LSL=0011, LSR=0100, SUB=0110, PassB=0111 and MUL=1000.
REQ-013 SHALL implement a three-state FSM with states IDLE, MUL and DONE.
REQ-014 SHALL drive InReady=1 only in IDLE; an operation is accepted on a rising edge where InValid and InReady are both 1.
REQ-015 SHALL, on acceptance of a non-MUL opcode, register BusW and all flags and enter DONE, so that OutValid=1 in the cycle after acceptance (latency 1).
REQ-016 SHALL, on acceptance of MUL, latch both operands, enter MUL and iterate shift-add for exactly WIDTH cycles, then enter DONE (OutValid WIDTH+1 cycles after acceptance).
REQ-017 SHALL, in DONE, hold OutValid=1 with BusW and flags stable until a rising edge with OutReady=1, then return to IDLE.
REQ-018 SHALL not return to IDLE and accept a new operation in the same cycle as a result handoff (InReady=0 in DONE).
REQ-019 SHALL ignore InValid and any BusA, BusB or ALUCtrl changes while not in IDLE.
REQ-020 SHALL use Zero = (BusW == 0) and Negative = BusW[WIDTH-1] for every opcode.
REQ-021 SHALL, for ADD, set Carry to the unsigned carry-out and Overflow to the signed overflow.
REQ-022 SHALL, for SUB, compute BusA - BusB with Carry=1 when no borrow occurs (BusA >= BusB unsigned) and Overflow set to the signed overflow.
REQ-023 SHALL, for LSL and LSR, shift BusA logically by BusB[log2(WIDTH)-1:0].
REQ-024 SHALL, for MUL, produce the low WIDTH bits of the unsigned product.
REQ-025 SHALL force Carry=0 and Overflow=0 for AND, OR, PassB, LSL, LSR and MUL.
REQ-026 SHALL, for an undefined opcode, complete with latency 1 with BusW=0, Zero=1 and all other flags 0.

Reset
REQ-027 SHALL, while Reset=1, asynchronously force state=IDLE, OutValid=0, BusW=0, all flags 0 and the iteration counter to 0.
REQ-028 SHALL drive InReady=1 from the first edge after Reset deasserts.
REQ-029 SHALL, if Reset asserts mid-MUL or in DONE, discard the operation and never present its result.

Configuration
REQ-030 SHALL compile the MUL opcode and multiplier datapath in only when macro MULTICYCLE_ALU_MUL_EN is defined.
REQ-031 SHALL, without MULTICYCLE_ALU_MUL_EN, treat opcode 1000 as undefined (per REQ-026), and the MUL state SHALL be unreachable and optimisable away.

Structure
REQ-032 SHALL take the opcode constants and the FSM state encoding from shared package alu_pkg.
REQ-033 SHALL place the iterative multiplier in sub-module alu_mul_unit (start/done handshake, WIDTH-parametrised), instantiated only under MULTICYCLE_ALU_MUL_EN.

Verification (WIDTH=64)
REQ-034 SHALL cover: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> BusW=0, Zero=1, Carry=1, Overflow=0, OutValid one cycle after acceptance.
REQ-035 SHALL cover: SUB 0x7FFF_FFFF_FFFF_FFFF - 0xFFFF_FFFF_FFFF_FFFF -> BusW=0x8000_0000_0000_0000, Negative=1, Overflow=1, Carry=0.
REQ-036 SHALL cover: MUL 7 x 9 with the macro defined -> BusW=63, OutValid exactly 65 cycles after acceptance, InReady=0 throughout.
REQ-037 SHALL cover: OutReady held low for 5 cycles after a result with InValid pulsed -> BusW and flags stable, no new acceptance, IDLE one cycle after OutReady=1.
REQ-038 SHALL cover: Reset asserted at MUL iteration 10 -> OutValid=0 and IDLE immediately; a following OR 0xF0 | 0x0F -> BusW=0xFF.
REQ-039 SHALL cover: macro undefined, opcode 1000 -> BusW=0, Zero=1, latency 1.
